// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered, held for ALU_LAT cycles, then the result is captured into a tagged response.
module alu_arbiter #(
    parameter int unsigned ALU_LAT    = 1,
    parameter bit          RESET_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [3:0] r0_op,
    input  logic [7:0] r0_a,
    input  logic [7:0] r0_b,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [3:0] r1_op,
    input  logic [7:0] r1_a,
    input  logic [7:0] r1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_cout,
    output logic       rsp_err,
    output logic [3:0] alu_c,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_s,
    input  logic       alu_cout,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] c_q, c_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       id_q, id_d;
    logic [7:0] res_q, res_d;
    logic       cout_q, cout_d;
    logic       err_q, err_d;

    logic       gnt_id;
    logic [3:0] sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    function automatic logic op_defined(input logic [3:0] op);
        case (op)
            4'h0, 4'h5, 4'hE, 4'hF: return 1'b0;
            default:                return 1'b1;
        endcase
    endfunction

    always_comb begin
        if (r0_valid && r1_valid) gnt_id = ptr_q;
        else                      gnt_id = r1_valid;
        sel_op = gnt_id ? r1_op : r0_op;
        sel_a  = gnt_id ? r1_a  : r0_a;
        sel_b  = gnt_id ? r1_b  : r0_b;
        // Gated by rst_n so every output reads 0 while reset is held.
        r0_ready = rst_n && (state_q == IDLE) && r0_valid && !gnt_id;
        r1_ready = rst_n && (state_q == IDLE) && r1_valid &&  gnt_id;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        res_d   = res_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (r0_ready || r1_ready) begin
                    id_d = gnt_id;
                    if (op_defined(sel_op)) begin
                        c_d     = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_op[3] ? 8'h00 : sel_b;
                        cnt_d   = CNT_INIT;
                        state_d = EXEC;
                    end else begin
                        res_d   = '0;
                        cout_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_s;
                    cout_d  = alu_cout;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= RESET_PRIO;
            cnt_q   <= '0;
            c_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign rsp_err    = err_q;
    assign alu_c      = c_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance at ALU_LAT=1 for arbitration and
// datapath scenarios, a second at ALU_LAT=4 for settle latency and response stalls.
module tb_alu_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       cout;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [3:0] r0_op, r1_op;
    logic [7:0] r0_a, r0_b, r1_a, r1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
    logic [7:0] rsp_result;
    logic [3:0] alu_c;
    logic [7:0] alu_a, alu_b, alu_s;
    logic       alu_cout, busy;

    logic       b_r0_valid, b_r0_ready, b_r1_ready;
    logic [3:0] b_r0_op;
    logic [7:0] b_r0_a, b_r0_b;
    logic       b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_cout, b_rsp_err;
    logic [7:0] b_rsp_result;
    logic [3:0] b_alu_c;
    logic [7:0] b_alu_a, b_alu_b, b_alu_s;
    logic       b_alu_cout, b_busy;

    int   errors = 0;
    int   checks = 0;
    int   pend0 = 0;
    int   pend1 = 0;
    exp_t sb[$];
    logic grants[$];

    always #5 clk = ~clk;

    // Reference ALU: {cout, s}; unary ops look at A only.
    function automatic logic [8:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'h1: return {1'b0, a} + {1'b0, b};
            4'h2: return {1'b0, a} - {1'b0, b};
            4'h3: return {1'b0, a & b};
            4'h4: return {1'b0, a | b};
            4'h6: return {1'b0, a ^ b};
            4'h7: return {1'b0, a} + {1'b0, b} + 9'd1;
            4'h8: return {1'b0, ~a};
            4'h9: return {1'b0, a} + 9'd1;
            4'hA: return {1'b0, a} - 9'd1;
            4'hB: return {a, 1'b0};
            4'hC: return {a[0], 1'b0, a[7:1]};
            4'hD: return {1'b0, a[6:0], a[7]};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic op_undef(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h5) || (op == 4'hE) || (op == 4'hF);
    endfunction

    assign {alu_cout, alu_s}     = alu_model(alu_c, alu_a, alu_b);
    assign {b_alu_cout, b_alu_s} = alu_model(b_alu_c, b_alu_a, b_alu_b);

    alu_arbiter #(.ALU_LAT(1), .RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cout(alu_cout),
        .busy(busy)
    );

    alu_arbiter #(.ALU_LAT(4), .RESET_PRIO(1'b0)) dut_lat4 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_op(b_r0_op), .r0_a(b_r0_a), .r0_b(b_r0_b),
        .r1_valid(1'b0), .r1_ready(b_r1_ready), .r1_op(4'h0), .r1_a(8'h00), .r1_b(8'h00),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_result(b_rsp_result), .rsp_cout(b_rsp_cout), .rsp_err(b_rsp_err),
        .alu_c(b_alu_c), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_s(b_alu_s), .alu_cout(b_alu_cout),
        .busy(b_busy)
    );

    task automatic push_exp(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [8:0] r;
        e.id = id;
        if (op_undef(op)) begin
            e.res = 8'h00; e.cout = 1'b0; e.err = 1'b1;
        end else begin
            r = alu_model(op, a, op[3] ? 8'h00 : b);
            e.res = r[7:0]; e.cout = r[8]; e.err = 1'b0;
        end
        sb.push_back(e);
        grants.push_back(id);
    endtask

    // One clock: observe accepts/responses at negedge, update requesters just after posedge.
    task automatic cycle();
        logic acc0, acc1;
        exp_t e;
        @(negedge clk);
        acc0 = r0_valid && r0_ready;
        acc1 = r1_valid && r1_ready;
        if (acc0) push_exp(1'b0, r0_op, r0_a, r0_b);
        if (acc1) push_exp(1'b1, r1_op, r1_a, r1_b);
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d res=%h, expected no response", rsp_id, rsp_result);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_result, rsp_cout, rsp_err} !== {e.id, e.res, e.cout, e.err}) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d res=%h cout=%b err=%b, expected id=%0d res=%h cout=%b err=%b",
                             rsp_id, rsp_result, rsp_cout, rsp_err, e.id, e.res, e.cout, e.err);
                end
            end
        end
        @(posedge clk);
        #1;
        if (acc0 && pend0 > 0) pend0--;
        if (acc1 && pend1 > 0) pend1--;
        r0_valid = (pend0 != 0);
        r1_valid = (pend1 != 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || pend0 != 0 || pend1 != 0) && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles pending=%0d, expected drain under 200", name, n, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0_valid = 1'b1; r0_op = 4'h1; r0_a = 8'h11; r0_b = 8'h22;
        #3;
        checks++;
        if ({r0_ready, r1_ready, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got r0=%b r1=%b busy=%b, expected 0 0 0", r0_ready, r1_ready, busy);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_err, rsp_result} !== 12'h000) begin
            errors++; $display("FAIL reset_rsp: got valid=%b id=%b res=%h, expected all 0", rsp_valid, rsp_id, rsp_result);
        end
        checks++;
        if ({alu_c, alu_a, alu_b} !== 20'h00000) begin
            errors++; $display("FAIL reset_alu: got c=%h a=%h b=%h, expected 0 0 0", alu_c, alu_a, alu_b);
        end
        r0_valid = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fairness();
        r0_op = 4'h2; r0_a = 8'hCE; r0_b = 8'hB5;
        r1_op = 4'h3; r1_a = 8'h64; r1_b = 8'h9C;
        pend0 = 4; pend1 = 4;
        r0_valid = 1'b1; r1_valid = 1'b1;
        grants.delete();
        wait_idle("fair");
        checks++;
        if (grants.size() != 8) begin
            errors++; $display("FAIL fair_count: got %0d grants, expected 8", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            checks++;
            if (grants[i] !== 1'(i % 2)) begin
                errors++; $display("FAIL fair_order[%0d]: got id=%b, expected %0d", i, grants[i], i % 2);
            end
        end
    endtask

    task automatic test_single();
        r0_op = 4'h1; r0_a = 8'h32; r0_b = 8'h32;
        pend0 = 1; r0_valid = 1'b1;
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got r0=%b r1=%b, expected 1 0", r0_ready, r1_ready);
        end
        cycle();
        checks++;
        if ({alu_c, alu_a, alu_b} !== {4'h1, 8'h32, 8'h32}) begin
            errors++; $display("FAIL single_alu: got c=%h a=%h b=%h, expected 1 32 32", alu_c, alu_a, alu_b);
        end
        checks++;
        if ({rsp_valid, busy, r0_ready} !== 3'b010) begin
            errors++; $display("FAIL single_exec: got valid=%b busy=%b ready=%b, expected 0 1 0", rsp_valid, busy, r0_ready);
        end
        cycle();
        checks++;
        if ({rsp_valid, rsp_id} !== 2'b10) begin
            errors++; $display("FAIL single_latency: got valid=%b id=%b, expected 1 0", rsp_valid, rsp_id);
        end
        wait_idle("single");
    endtask

    task automatic test_error();
        r1_op = 4'h5; r1_a = 8'hAA; r1_b = 8'h55;
        pend1 = 1; r1_valid = 1'b1;
        cycle();
        checks++;
        if ({rsp_valid, rsp_err, rsp_cout, rsp_id, rsp_result} !== {4'b1101, 8'h00}) begin
            errors++; $display("FAIL err_rsp: got valid=%b err=%b cout=%b id=%b res=%h, expected 1 1 0 1 00",
                               rsp_valid, rsp_err, rsp_cout, rsp_id, rsp_result);
        end
        checks++;
        if ({alu_c, alu_a, alu_b} !== {4'h1, 8'h32, 8'h32}) begin
            errors++; $display("FAIL err_alu_held: got c=%h a=%h b=%h, expected 1 32 32", alu_c, alu_a, alu_b);
        end
        wait_idle("error");
    endtask

    task automatic test_unary();
        r0_op = 4'h8; r0_a = 8'hCD; r0_b = 8'hFF;
        pend0 = 1; r0_valid = 1'b1;
        cycle();
        checks++;
        if ({alu_c, alu_a, alu_b} !== {4'h8, 8'hCD, 8'h00}) begin
            errors++; $display("FAIL unary_alu: got c=%h a=%h b=%h, expected 8 cd 00", alu_c, alu_a, alu_b);
        end
        wait_idle("unary");
    endtask

    task automatic test_back_to_back();
        r0_op = 4'h9; r0_a = 8'hFF; r0_b = 8'h00;
        pend0 = 3; r0_valid = 1'b1;
        grants.delete();
        wait_idle("b2b");
        checks++;
        if (grants.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d grants, expected 3", grants.size());
        end
        foreach (grants[i]) begin
            checks++;
            if (grants[i] !== 1'b0) begin
                errors++; $display("FAIL b2b_order[%0d]: got id=%b, expected 0", i, grants[i]);
            end
        end
    endtask

    task automatic test_reset_exec();
        r0_op = 4'h4; r0_a = 8'h0F; r0_b = 8'hF0;
        pend0 = 1; r0_valid = 1'b1;
        cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rexec_busy: got %b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, r0_ready, r1_ready, rsp_result, alu_c, alu_a, alu_b} !== 32'h0) begin
            errors++; $display("FAIL rexec_clear: got valid=%b busy=%b c=%h a=%h b=%h res=%h, expected all 0",
                               rsp_valid, busy, alu_c, alu_a, alu_b, rsp_result);
        end
        sb.delete();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rexec_no_rsp[%0d]: got valid=%b, expected 0", i, rsp_valid);
            end
        end
        r0_op = 4'h6; r0_a = 8'h5A; r0_b = 8'hFF;
        r1_op = 4'h7; r1_a = 8'hFF; r1_b = 8'h00;
        pend0 = 1; pend1 = 1; r0_valid = 1'b1; r1_valid = 1'b1;
        grants.delete();
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++; $display("FAIL rexec_prio: got r0=%b r1=%b, expected 1 0", r0_ready, r1_ready);
        end
        wait_idle("rexec");
        checks++;
        if (grants.size() != 2 || grants[0] !== 1'b0 || grants[1] !== 1'b1) begin
            errors++; $display("FAIL rexec_order: got %0d grants, expected 0 then 1", grants.size());
        end
    endtask

    task automatic test_latency_stall();
        int   edges;
        logic rdy_bad;
        b_r0_op = 4'h1; b_r0_a = 8'h90; b_r0_b = 8'h80;
        b_r0_valid = 1'b1; b_rsp_ready = 1'b0;
        #1;
        checks++;
        if (b_r0_ready !== 1'b1) begin
            errors++; $display("FAIL lat_ready: got %b, expected 1", b_r0_ready);
        end
        @(posedge clk);
        #1;
        b_r0_op = 4'h3; b_r0_a = 8'h0F; b_r0_b = 8'h3C;
        edges = 0; rdy_bad = 1'b0;
        while (!b_rsp_valid && edges < 20) begin
            if (b_r0_ready || b_r1_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (edges != 4) begin
            errors++; $display("FAIL lat_edges: got %0d, expected 4", edges);
        end
        for (int i = 0; i < 3; i++) begin
            if (b_r0_ready || b_r1_ready) rdy_bad = 1'b1;
            checks++;
            if ({b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_cout, b_rsp_result} !== {4'b1001, 8'h10}) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b id=%b err=%b cout=%b res=%h, expected 1 0 0 1 10",
                                   i, b_rsp_valid, b_rsp_id, b_rsp_err, b_rsp_cout, b_rsp_result);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rdy_bad !== 1'b0) begin
            errors++; $display("FAIL stall_ready: got ready during EXEC/RESP=%b, expected 0", rdy_bad);
        end
        checks++;
        if (b_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL stall_still_valid: got %b, expected 1", b_rsp_valid);
        end
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({b_rsp_valid, b_busy, b_r0_ready} !== 3'b001) begin
            errors++; $display("FAIL stall_done: got valid=%b busy=%b ready=%b, expected 0 0 1", b_rsp_valid, b_busy, b_r0_ready);
        end
        b_r0_valid = 1'b0;
    endtask

    initial begin
        r1_valid = 1'b0; r1_op = 4'h0; r1_a = 8'h00; r1_b = 8'h00;
        rsp_ready = 1'b1;
        b_r0_valid = 1'b0; b_r0_op = 4'h0; b_r0_a = 8'h00; b_r0_b = 8'h00; b_rsp_ready = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_error();
        test_unary();
        test_back_to_back();
        test_reset_exec();
        test_latency_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (4-bit opcode C, operands A/B, result s, carry cout) between two requesters.
- Round-robin arbitration; valid/ready request handshake per requester; one shared response channel tagged with requester id.
- Registers the operands and opcode, waits a programmable settle time, captures the ALU outputs, and rejects undefined opcodes without issuing them.
- Sits between the two command sources and the ALU instance in the datapath.

Parameters:
ALU_LAT, 1, cycles (1..15) alu_* outputs are held stable before alu_s/alu_cout are captured
RESET_PRIO, 0, requester holding priority after reset (0 or 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
r0_valid  in  1  requester 0 command valid
r0_ready  out  1  requester 0 command accepted this cycle when high with r0_valid
r0_op  in  4  requester 0 opcode
r0_a  in  8  requester 0 operand A
r0_b  in  8  requester 0 operand B
r1_valid  in  1  requester 1 command valid
r1_ready  out  1  requester 1 ready
r1_op  in  4  requester 1 opcode
r1_a  in  8  requester 1 operand A
r1_b  in  8  requester 1 operand B
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that owns the response
rsp_result  out  8  captured alu_s (0 on error)
rsp_cout  out  1  captured alu_cout (0 on error)
rsp_err  out  1  opcode was undefined; ALU not issued
alu_c  out  4  ALU opcode
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_s  in  8  ALU result
alu_cout  in  1  ALU carry out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: rsp_*, alu_c/a/b, r0_ready, r1_ready. Priority pointer = RESET_PRIO. Settle counter = 0.
- Defined opcodes:
  - Binary: 0001–0100 and 0110–0111.
  - Unary (uses A only): 1000–1101.
  - Undefined: 0000, 0101, 1110, 1111.
- Ready is combinational.
  - In IDLE, rX_ready = 1 for the granted requester only.
  - Grant goes to the only valid requester; if both are valid, to the pointer requester.
  - Outside IDLE both readys are 0.
  - A command is accepted at the edge where valid&ready=1.
- Requesters hold valid/op/a/b stable until accepted. Valid is not withdrawn while unaccepted.
- On accept with a defined opcode:
  - Latch op, a, and b into alu_c/alu_a/alu_b. For unary ops alu_b is latched as 0.
  - Latch the id, load counter = ALU_LAT-1, go to EXEC.
- On accept with an undefined opcode:
  - alu_c/a/b keep their previous values.
  - Go directly to RESP with result=0, cout=0, err=1, id latched.
- EXEC:
  - alu_* are held constant.
  - When counter==0: at that edge capture alu_s→rsp_result and alu_cout→rsp_cout, set err=0, go to RESP. Otherwise decrement the counter.
  - Latency: rsp_valid rises ALU_LAT edges after the accept edge.
- RESP:
  - rsp_valid=1; rsp_result, rsp_cout, rsp_err and rsp_id are held stable until rsp_valid&rsp_ready.
  - At the completing edge: rsp_valid→0, state→IDLE, pointer→(rsp_id^1).
  - Earliest next accept is the edge after return to IDLE, so each transaction takes at least one IDLE cycle.
- alu_c/a/b are not cleared after a transaction. They keep the last issued values.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1. A lone requester is granted back-to-back regardless of the pointer.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values. The in-flight transaction is discarded with no response.
- rsp_ready asserted while rsp_valid=0 has no effect.

Test Plan:
- Only r0_valid, op=0001, A=0x32, B=0x32, rsp_ready=1, ALU_LAT=1 -> r0_ready=1 in IDLE; alu_c=0001, alu_a=0x32, alu_b=0x32 after accept; rsp_valid the next cycle with rsp_id=0 and rsp_result/rsp_cout equal to the ALU's outputs for those operands.
- Both valid continuously (r0: op 0010, A=0xCE, B=0xB5; r1: op 0011, A=0x64, B=0x9C), RESET_PRIO=0 -> rsp_id sequence 0,1,0,1; no requester granted twice in a row.
- r1 op=0101 -> rsp_valid with rsp_err=1, rsp_result=0x00, rsp_cout=0, rsp_id=1; alu_c/a/b unchanged from the previous transaction.
- Unary op 1000, A=0xCD, B=0xFF -> alu_b driven as 0x00 while alu_a=0xCD.
- ALU_LAT=4, rsp_ready held 0 for 3 cycles -> rsp_valid rises 4 edges after accept; rsp_result, rsp_cout, rsp_err and rsp_id stable for all 3 stall cycles; both readys 0 throughout.
- rst_n pulsed low during EXEC -> all outputs 0 asynchronously; no response delivered; next accept proceeds normally with pointer=RESET_PRIO.
